// File: rtl/register_file.sv
// register_file: 2^ADDR_WIDTH x WIDTH general-purpose register file for the lab CPU.
// Two combinational read ports and one clocked write port; register 0 always reads zero.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to the read
// ports. Without it, reads reflect stored state only.
module register_file #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic                  RegWrite,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] regs [DEPTH];

  // A commit happens only for an enabled write to a nonzero register outside reset
  logic write_commit_c;
  assign write_commit_c = RegWrite && !reset && (WriteRegister != '0);

  // Storage update: reset clears everything and overrides any write on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (write_commit_c) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Read port 1: zero for register 0, otherwise stored (or forwarded) value
  always_comb begin
    ReadData1 = '0;
    if (ReadRegister1 != '0) begin
      ReadData1 = regs[ReadRegister1];
`ifdef REGFILE_BYPASS_EN
      if (write_commit_c && (ReadRegister1 == WriteRegister)) begin
        ReadData1 = WriteData;
      end
`endif
    end
  end

  // Read port 2: same behaviour as port 1, independent address
  always_comb begin
    ReadData2 = '0;
    if (ReadRegister2 != '0) begin
      ReadData2 = regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
      if (write_commit_c && (ReadRegister2 == WriteRegister)) begin
        ReadData2 = WriteData;
      end
`endif
    end
  end

endmodule
